bmem_burst_responder: RTL and testbench



---
 rtl/bmem_burst_responder.sv | 176 +++++++++++++++++
 tb/tb_bmem_burst_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_burst_responder.sv
// Burst-memory responder: accepts line reads and 4-beat line writes on the bmem
// interface and returns each read line as 4 consecutive 64-bit beats after a fixed latency.
`timescale 1ns/1ps
module bmem_burst_responder #(
  parameter int unsigned LINES        = 256,
  parameter int unsigned READ_LATENCY = 8,
  parameter int unsigned QUEUE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [5:0]  CD_INIT = 6'(READ_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_BEAT2, S_BEAT3} state_t;

  logic [255:0]   mem_q   [LINES];
  logic [26:0]    qaddr_q [QUEUE_DEPTH];
  logic [5:0]     qcnt_q  [QUEUE_DEPTH];

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;
  logic [255:0]   line_q, line_d;
  logic [26:0]    raddr_q, raddr_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [1:0]     wbeat_q, wbeat_d;
  logic [26:0]    wbase_q, wbase_d;
  logic           perr_q, perr_d;

  logic           wr_en, push, pop, start, head_ready, next_ready;
  logic [PW-1:0]  next_ptr, start_ptr;
  logic [IW-1:0]  w_idx, s_idx;
  logic           unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (32'(p) == 32'(QUEUE_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign unused_addr_bits = ^bmem_addr[4:0];

  assign bmem_ready  = !rst && (count_q < CW'(QUEUE_DEPTH));
  assign bmem_rvalid = (state_q != S_IDLE);
  assign bmem_raddr  = {raddr_q, 5'b0};
  assign bmem_rdata  = rdata_q;
  assign proto_err   = perr_q;

  assign wr_en    = bmem_write && bmem_ready;
  assign push     = bmem_read && bmem_ready && !bmem_write;
  assign pop      = (state_q == S_BEAT3);
  assign w_idx    = bmem_addr[5 +: IW];
  assign next_ptr = ptr_inc(rd_ptr_q);

  // Countdowns are checked one cycle early (<=1) so the registered beat lands
  // exactly when the entry's countdown reaches zero.
  assign head_ready = (count_q != '0) && (qcnt_q[rd_ptr_q] <= 6'd1);
  assign next_ready = (count_q > CW'(1)) && (qcnt_q[next_ptr] <= 6'd1);

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_ptr = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (head_ready) begin
          state_d = S_BEAT0;
          start   = 1'b1;
        end
      end
      S_BEAT0: state_d = S_BEAT1;
      S_BEAT1: state_d = S_BEAT2;
      S_BEAT2: state_d = S_BEAT3;
      S_BEAT3: begin
        if (next_ready) begin
          state_d   = S_BEAT0;
          start     = 1'b1;
          start_ptr = next_ptr;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write beat committed on the capture edge is merged into the captured line.
  always_comb begin
    line_d  = line_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    s_idx   = qaddr_q[start_ptr][IW-1:0];
    if (start) begin
      line_d = mem_q[s_idx];
      if (wr_en && (w_idx == s_idx)) line_d[{wbeat_q, 6'd0} +: 64] = bmem_wdata;
      raddr_d = qaddr_q[start_ptr];
    end
    case (state_d)
      S_BEAT0: rdata_d = line_d[63:0];
      S_BEAT1: rdata_d = line_d[127:64];
      S_BEAT2: rdata_d = line_d[191:128];
      S_BEAT3: rdata_d = line_d[255:192];
      default: rdata_d = rdata_q;
    endcase
  end

  always_comb begin
    wbeat_d  = wr_en ? wbeat_q + 2'd1 : wbeat_q;
    wbase_d  = wr_en ? bmem_addr[31:5] : wbase_q;
    perr_d   = perr_q
             | (bmem_read && !bmem_ready)
             | (bmem_read && bmem_write && bmem_ready)
             | (wr_en && (wbeat_q != 2'd0) && (bmem_addr[31:5] != wbase_q));
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      line_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      wbeat_q  <= '0;
      wbase_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      line_q   <= line_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      wbeat_q  <= wbeat_d;
      wbase_q  <= wbase_d;
      perr_q   <= perr_d;
    end
  end

  // Queue payload needs no reset: entries are only looked at while count_q covers them.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      qcnt_q[i] <= (qcnt_q[i] == 6'd0) ? 6'd0 : qcnt_q[i] - 6'd1;
    end
    if (push) begin
      qaddr_q[wr_ptr_q] <= bmem_addr[31:5];
      qcnt_q[wr_ptr_q]  <= CD_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[w_idx][{wbeat_q, 6'd0} +: 64] <= bmem_wdata;
  end

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Bench for bmem_burst_responder: directed table and sequences plus random traffic
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_bmem_burst_responder;

  localparam int unsigned LINES = 256;
  localparam int unsigned RL    = 8;
  localparam int unsigned QD    = 4;
  localparam int unsigned IW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready, bmem_rvalid, proto_err;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bmem_burst_responder #(
    .LINES(LINES),
    .READ_LATENCY(RL),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bmem_addr(bmem_addr),
    .bmem_read(bmem_read),
    .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    rst = r; bmem_read = rd; bmem_write = wr; bmem_addr = a; bmem_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [63:0] mk(input logic [15:0] tag, input int b);
    return {tag, 48'(b)};
  endfunction

  task automatic wburst(input logic [31:0] a, input logic [15:0] tag);
    for (int b = 0; b < 4; b++) drive(1'b0, 1'b0, 1'b1, a, mk(tag, b));
  endtask

  // Read from an idle responder and check the full return timing and data.
  task automatic read_line(input string tag, input logic [31:0] a,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e [4];
    e = '{e0, e1, e2, e3};
    drive(1'b0, 1'b1, 1'b0, a, '0);
    chk({tag, "_acc_ready"}, bmem_ready, 1'b1);
    for (int k = 1; k < RL; k++) begin
      idle();
      chk({tag, "_early_rvalid"}, bmem_rvalid, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      idle();
      chk($sformatf("%s_b%0d_rvalid", tag, b), bmem_rvalid, 1'b1);
      chk($sformatf("%s_b%0d_raddr", tag, b), bmem_raddr, {a[31:5], 5'b0});
      chk($sformatf("%s_b%0d_rdata", tag, b), bmem_rdata, e[b]);
    end
    idle();
    chk({tag, "_end_rvalid"}, bmem_rvalid, 1'b0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [26:0] la;
    int          acc;
  } pend_t;

  pend_t       q_m[$];
  logic [63:0] mem_m [LINES][4];
  logic [63:0] line_m [4];
  bit          act_m = 0;
  int          start_m = 0;
  bit          perr_m = 0;
  int          wbeat_m = 0;
  logic [26:0] wbase_m = '0;
  int          cyc = 0;
  bit          synced = 0;

  always @(negedge clk) begin
    bit ready_e;
    cyc++;
    if (act_m && cyc == start_m + 4) begin
      act_m = 0;
      void'(q_m.pop_front());
    end
    if (!act_m && q_m.size() > 0 && q_m[0].acc + int'(RL) <= cyc) begin
      act_m   = 1;
      start_m = cyc;
      for (int b = 0; b < 4; b++) line_m[b] = mem_m[q_m[0].la[IW-1:0]][b];
    end
    ready_e = !rst && (q_m.size() < int'(QD));
    if (synced) begin
      chk("m_ready", bmem_ready, ready_e);
      chk("m_rvalid", bmem_rvalid, act_m);
      chk("m_perr", proto_err, perr_m);
      if (act_m) begin
        chk("m_raddr", bmem_raddr, {q_m[0].la, 5'b0});
        chk("m_rdata", bmem_rdata, line_m[cyc - start_m]);
      end
    end
    if (rst) begin
      q_m.delete();
      act_m   = 0;
      perr_m  = 0;
      wbeat_m = 0;
      synced  = 1;
    end else begin
      if (bmem_read && !ready_e) perr_m = 1;
      if (bmem_write && ready_e) begin
        if (wbeat_m != 0 && bmem_addr[31:5] != wbase_m) perr_m = 1;
        if (bmem_read) perr_m = 1;
        mem_m[bmem_addr[5 +: IW]][wbeat_m] = bmem_wdata;
        wbeat_m = (wbeat_m + 1) % 4;
        wbase_m = bmem_addr[31:5];
      end
      if (bmem_read && ready_e && !bmem_write) q_m.push_back('{la: bmem_addr[31:5], acc: cyc});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        e_ready;
    logic        e_rvalid;
    logic [31:0] e_raddr;
    logic [63:0] e_rdata;
    logic        e_perr;
  } vec_t;

  initial begin
    vec_t        tv [17];
    logic [63:0] pat [4];
    logic [31:0] a5 [5];
    bit          acc5;
    int          acc_k;
    int          wcnt;
    int          r;
    logic [31:0] wa;

    pat = '{{8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}};
    for (int i = 0; i < 17; i++)
      tv[i] = '{rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, e_ready: 1'b1,
                e_rvalid: 1'b0, e_raddr: '0, e_rdata: '0, e_perr: 1'b0};
    for (int i = 0; i < 4; i++) begin
      tv[i].wr = 1'b1; tv[i].addr = 32'h0000_1040; tv[i].wdata = pat[i];
    end
    tv[4].rd = 1'b1; tv[4].addr = 32'h0000_1040;
    for (int i = 12; i < 16; i++) begin
      tv[i].e_rvalid = 1'b1; tv[i].e_raddr = 32'h0000_1040; tv[i].e_rdata = pat[i-12];
    end

    // reset
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rst_ready", bmem_ready, 1'b0);
    idle();
    chk("rst_rvalid", bmem_rvalid, 1'b0);
    chk("rst_raddr", bmem_raddr, 32'h0);
    chk("rst_rdata", bmem_rdata, 64'h0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_ready_after", bmem_ready, 1'b1);

    // write burst then read, beats at T+8..T+11
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata);
      chk($sformatf("tv%0d_ready", i), bmem_ready, tv[i].e_ready);
      chk($sformatf("tv%0d_rvalid", i), bmem_rvalid, tv[i].e_rvalid);
      chk($sformatf("tv%0d_perr", i), proto_err, tv[i].e_perr);
      if (tv[i].e_rvalid) begin
        chk($sformatf("tv%0d_raddr", i), bmem_raddr, tv[i].e_raddr);
        chk($sformatf("tv%0d_rdata", i), bmem_rdata, tv[i].e_rdata);
      end
    end

    // paused burst, then aliased reads
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1040, mk(16'hA5A5, 0));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1040, mk(16'hA5A5, 1));
    repeat (3) idle();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1040, mk(16'hA5A5, 2));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1040, mk(16'hA5A5, 3));
    idle();
    chk("pause_perr", proto_err, 1'b0);
    read_line("alias0", 32'h0000_1040, mk(16'hA5A5, 0), mk(16'hA5A5, 1), mk(16'hA5A5, 2), mk(16'hA5A5, 3));
    read_line("alias8", 32'h8000_1040, mk(16'hA5A5, 0), mk(16'hA5A5, 1), mk(16'hA5A5, 2), mk(16'hA5A5, 3));

    // write ending two cycles before read accept is fully visible
    wburst(32'h0000_2000, 16'hD000);
    wburst(32'h0000_2000, 16'hD100);
    idle();
    read_line("wr_before", 32'h0000_2000, mk(16'hD100, 0), mk(16'hD100, 1), mk(16'hD100, 2), mk(16'hD100, 3));

    // burst straddling the capture: beats 0,1 commit by the BEAT0 edge, beats 2,3 do not
    drive(1'b0, 1'b1, 1'b0, 32'h0000_2000, '0);
    for (int k = 1; k < 12; k++) begin
      if (k >= 6 && k <= 9) drive(1'b0, 1'b0, 1'b1, 32'h0000_2000, mk(16'hD200, k - 6));
      else idle();
      chk($sformatf("straddle%0d_rvalid", k), bmem_rvalid, k >= 8);
      if (k >= 8)
        chk($sformatf("straddle%0d_rdata", k), bmem_rdata,
            (k - 8 < 2) ? mk(16'hD200, k - 8) : mk(16'hD100, k - 8));
    end
    idle();
    chk("straddle_end_rvalid", bmem_rvalid, 1'b0);

    // reset during BEAT1
    drive(1'b0, 1'b1, 1'b0, 32'h0000_2000, '0);
    for (int k = 1; k < 8; k++) idle();
    idle();
    chk("rstb_beat0_rvalid", bmem_rvalid, 1'b1);
    chk("rstb_beat0_rdata", bmem_rdata, mk(16'hD200, 0));
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rstb_beat1_rdata", bmem_rdata, mk(16'hD200, 1));
    chk("rstb_ready_in_rst", bmem_ready, 1'b0);
    idle();
    chk("rstb_rvalid_after", bmem_rvalid, 1'b0);
    chk("rstb_ready_after", bmem_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      idle();
      chk("rstb_no_beats", bmem_rvalid, 1'b0);
    end
    read_line("rstb_reread", 32'h0000_2000, mk(16'hD200, 0), mk(16'hD200, 1), mk(16'hD200, 2), mk(16'hD200, 3));

    // read and write in the same cycle
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3000, mk(16'hF000, 0));
    chk("rw_ready", bmem_ready, 1'b1);
    for (int b = 1; b < 4; b++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0000_3000, mk(16'hF000, b));
      chk("rw_perr_set", proto_err, 1'b1);
    end
    for (int k = 0; k < 12; k++) begin
      idle();
      chk("rw_no_return", bmem_rvalid, 1'b0);
    end
    read_line("rw_line", 32'h0000_3000, mk(16'hF000, 0), mk(16'hF000, 1), mk(16'hF000, 2), mk(16'hF000, 3));
    chk("rw_perr_sticky", proto_err, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle();
    chk("rw_perr_cleared", proto_err, 1'b0);

    // five reads against a 4-deep queue
    a5 = '{32'h0000_1040, 32'h8000_1040, 32'h4000_2000, 32'h0000_2000, 32'h1234_5040};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, a5[k], '0);
      chk($sformatf("five_acc%0d_ready", k), bmem_ready, 1'b1);
    end
    acc5 = 0;
    acc_k = -1;
    for (int k = 4; k < 30; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
      bmem_read = !acc5 && bmem_ready;
      bmem_addr = a5[4];
      @(negedge clk);
      chk($sformatf("five_k%0d_ready", k), bmem_ready, (k == 12) || (k >= 16));
      chk($sformatf("five_k%0d_rvalid", k), bmem_rvalid, (k >= 8) && (k <= 27));
      if (k == 8)  chk("five_first_raddr", bmem_raddr, 32'h0000_1040);
      if (k == 24) chk("five_last_raddr", bmem_raddr, 32'h1234_5040);
      if (bmem_read && bmem_ready) begin
        acc5 = 1;
        acc_k = k;
      end
    end
    chk("five_accept_cycle", 64'(acc_k), 64'd12);
    chk("five_perr", proto_err, 1'b0);

    // prefill lines 0..15 for random traffic
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++)
        drive(1'b0, 1'b0, 1'b1, 32'(i) << 5, {$urandom, $urandom});

    // random traffic, checked by the model only
    wcnt = 0;
    wa = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 999));
      rst = 1'b0; bmem_read = 1'b0; bmem_write = 1'b0;
      bmem_addr = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F);
      bmem_wdata = {$urandom, $urandom};
      if (r < 5) begin
        rst = 1'b1;
        wcnt = 0;
      end else if (r < 300) begin
        bmem_read = bmem_ready || (r < 20);
      end else if (r < 600) begin
        if (wcnt % 4 == 0 || r < 310) wa = bmem_addr;
        bmem_addr = wa;
        bmem_write = 1'b1;
        bmem_read = (r < 305);
        if (bmem_ready) wcnt++;
      end
      @(negedge clk);
    end
    repeat (40) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
